// File: rtl/mux_chsel_guarded.sv
// Registered N:1 channel selector with a valid/ack select handshake and a guard
// interval that holds the output steady while the channel switches over.
module mux_chsel_guarded #(
    parameter int P_WIDTH   = 1,
    parameter int P_NCH     = 2,
    parameter int P_SELW    = 4,
    parameter int P_GUARD   = 2,
    parameter int P_RST_SEL = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [P_NCH*P_WIDTH-1:0]   i_data,
    input  logic                       i_sel_valid,
    input  logic [P_SELW-1:0]          i_sel,
    output logic                       o_sel_ack,
    output logic                       o_sel_nack,
    output logic [P_WIDTH-1:0]         o_a,
    output logic [P_SELW-1:0]          o_sel_cur,
    output logic                       o_busy,
    output logic                       o_err_sel
);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_HOLD   = 1'b1
    } state_t;

    localparam int                NCODE    = 1 << P_SELW;
    // One extra bit so the range check holds even when P_NCH == 2**P_SELW.
    localparam logic [P_SELW:0]   NCH_EXT  = (P_SELW + 1)'(P_NCH);
    localparam logic [P_SELW-1:0] RST_SEL  = P_SELW'(P_RST_SEL);
    localparam logic [3:0]        GUARD_LD = (P_GUARD > 0) ? 4'(P_GUARD - 1) : 4'd0;

    // Unused select codes map to zero so the channel index is always full width.
    logic [P_WIDTH-1:0] ch [NCODE];

    for (genvar k = 0; k < NCODE; k++) begin : g_ch
        if (k < P_NCH) begin : g_used
            assign ch[k] = i_data[k*P_WIDTH +: P_WIDTH];
        end else begin : g_unused
            assign ch[k] = '0;
        end
    end

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [P_SELW-1:0]   pend_q, pend_d;
    logic [P_SELW-1:0]   sel_q, sel_d;
    logic [P_WIDTH-1:0]  a_q, a_d;
    logic                ack_q, ack_d;
    logic                nack_q, nack_d;
    logic                err_q, err_d;

    logic req_live;
    logic in_range;
    logic req_ok;
    logic req_bad;

    // A request is not re-evaluated while its ack/nack pulse is showing.
    assign req_live = i_sel_valid && !ack_q && !nack_q;
    assign in_range = ({1'b0, i_sel} < NCH_EXT);
    assign req_ok   = req_live && in_range;
    assign req_bad  = req_live && !in_range;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        a_d     = a_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_ACTIVE: begin
                a_d = ch[sel_q];
                if (req_ok) begin
                    ack_d  = 1'b1;
                    pend_d = i_sel;
                    if (P_GUARD == 0) begin
                        sel_d = i_sel;
                    end else begin
                        cnt_d   = GUARD_LD;
                        state_d = ST_HOLD;
                    end
                end else if (req_bad) begin
                    nack_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    sel_d   = pend_q;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments only.
        if (i_rst) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= 4'd0;
            pend_q  <= RST_SEL;
            sel_q   <= RST_SEL;
            a_q     <= '0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            err_q   <= err_d;
        end
    end

    assign o_sel_ack  = ack_q;
    assign o_sel_nack = nack_q;
    assign o_a        = a_q;
    assign o_sel_cur  = sel_q;
    assign o_busy     = (state_q == ST_HOLD);
    assign o_err_sel  = err_q;

    // Structural invariants, kept live in simulation and emulation builds.
    always @(posedge i_clk) begin
        if (!i_rst) begin
            a_sel_range : assert ({1'b0, sel_q} < NCH_EXT);
            a_ack_excl  : assert (!(ack_q && nack_q));
            a_busy_hold : assert (!o_busy || (state_q == ST_HOLD));
        end
    end

endmodule

// File: doc/mux_chsel_guarded.md
Name: mux_chsel_guarded

Overview:
- Parametrised, registered N:1 channel selector; successor to the 2:1 select-mux primitive used in the emulation test tops.
- Select changes go through a valid/ack handshake and a guard interval. During the guard interval the output holds its last value, so a switchover never passes a mixed or undefined sample.
- Out-of-range select requests are rejected and flagged sticky, so the block can be checked with immediate assertions in emulation.

Parameters:
- P_WIDTH, 1, data width per channel (>=1).
- P_NCH, 2, number of input channels (2..16).
- P_SELW, 4, select field width; must satisfy 2**P_SELW >= P_NCH.
- P_GUARD, 2, hold cycles between accepting a new select and driving the new channel (0..15).
- P_RST_SEL, 0, channel selected out of reset (< P_NCH).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_data  input  P_NCH*P_WIDTH  channel k occupies bits [k*P_WIDTH +: P_WIDTH].
- i_sel_valid  input  1  select change request.
- i_sel  input  P_SELW  requested channel; sampled when i_sel_valid=1.
- o_sel_ack  output  1  one-cycle pulse: request accepted (in range).
- o_sel_nack  output  1  one-cycle pulse: request rejected (i_sel >= P_NCH).
- o_a  output  P_WIDTH  registered selected data.
- o_sel_cur  output  P_SELW  channel currently driving o_a.
- o_busy  output  1  1 while in HOLD.
- o_err_sel  output  1  sticky out-of-range flag; cleared only by i_rst.

Behaviour:
- Reset (i_rst=1 at an edge), all values next cycle:
  - o_a=0, o_sel_cur=P_RST_SEL, o_busy=0, o_sel_ack=0, o_sel_nack=0, o_err_sel=0.
  - State=ACTIVE, guard counter=0.
  - i_rst has priority over every other event; reset mid-HOLD abandons the pending select.
- States: ACTIVE, HOLD.
- ACTIVE:
  - o_a <= i_data[o_sel_cur], giving 1-cycle latency from i_data to o_a.
  - If i_sel_valid and i_sel < P_NCH: pulse o_sel_ack, latch pending=i_sel.
    - P_GUARD>0: load counter=P_GUARD-1 and go to HOLD.
    - P_GUARD=0: o_sel_cur<=i_sel in the same edge; o_a that edge still samples the old channel.
  - If i_sel_valid and i_sel >= P_NCH: pulse o_sel_nack, set o_err_sel, stay ACTIVE, o_sel_cur unchanged.
  - A request with i_sel equal to o_sel_cur is accepted normally, guard included.
- HOLD:
  - o_busy=1 and o_a holds its value.
  - Counter decrements each cycle.
  - When the counter is 0: o_sel_cur<=pending, go to ACTIVE. o_a takes the new channel on the following edge.
  - HOLD lasts exactly P_GUARD cycles. The first new-channel sample appears on o_a P_GUARD+1 edges after the accept edge.
- Requests during HOLD:
  - i_sel_valid is ignored: no ack, no nack, no error.
  - The requester must hold i_sel_valid until it sees ack or nack. A request held across the end of HOLD is accepted in the first ACTIVE cycle.
- Handshake: ack and nack are mutually exclusive and never asserted for two consecutive cycles on one held request. After a pulse the block re-evaluates the still-held request, so the requester must drop i_sel_valid the cycle after ack or nack.
- Widths:
  - Channel index arithmetic is unsigned.
  - The range check compares the full P_SELW width; no truncation.
  - When P_NCH is not a power of two, unused codes are always nack.
- Simultaneous events: in the same cycle, the HOLD-to-ACTIVE transition and a pending i_sel_valid resolve as "request ignored". Acceptance occurs the next cycle.
- Embedded immediate assertions (simulation and emulation):
  - o_sel_cur < P_NCH always.
  - o_sel_ack & o_sel_nack never both 1.
  - o_busy implies state==HOLD.

Test Plan:
- P_NCH=4, P_WIDTH=8, P_GUARD=2; reset; i_data={8'h44,8'h33,8'h22,8'h11}, no request → o_a=8'h11 (ch0) one cycle after reset release, o_sel_cur=0.
- From that state, i_sel_valid=1, i_sel=2 for one cycle → o_sel_ack pulse; o_busy=1 for 2 cycles with o_a held at 8'h11; o_a=8'h33 on the 3rd edge after accept; o_sel_cur=2.
- i_sel=5 with P_NCH=4 → o_sel_nack pulse, o_err_sel=1 and stays 1; o_a/o_sel_cur unchanged; a later valid i_sel=1 is acked with o_err_sel still 1.
- During HOLD, apply i_sel_valid=1, i_sel=3 and keep it held → no ack during HOLD; ack on the first ACTIVE cycle; then o_sel_cur=3 after a further 2-cycle HOLD.
- P_GUARD=0: i_sel=1 accepted → o_sel_cur=1 next cycle and o_busy never asserts; o_a shows ch0 data on the accept edge and ch1 data on the next edge.
- Assert i_rst in the middle of HOLD (pending=3) → next cycle o_sel_cur=P_RST_SEL, o_busy=0, o_a=0, o_err_sel=0, and the pending select is discarded.
